// File: rtl/square_pkg.sv
// Shared constants, position type, FSM states and per-axis helpers for the square mover.
// Build option: define SQUARE_COLLISION_EN to add the CHECK overlap-scan state.
package square_pkg;

  localparam logic [9:0] X_MAX       = 10'd640;
  localparam logic [9:0] Y_MAX       = 10'd480;
  localparam logic [9:0] SQUARE_SIZE = 10'd30;
  localparam logic [9:0] CHANGES     = 10'd5;
  localparam logic [9:0] X_LIM       = X_MAX - SQUARE_SIZE;
  localparam logic [9:0] Y_LIM       = Y_MAX - SQUARE_SIZE;

  typedef struct packed {
    logic [9:0] y;
    logic [9:0] x;
  } pos_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
`ifdef SQUARE_COLLISION_EN
    ST_CHECK   = 3'd4,
`endif
    ST_WRITE   = 3'd3
  } state_t;

  // dec pulls toward 0, inc pulls toward lim; both or neither leaves the axis alone
  function automatic logic [9:0] axis_step(input logic [9:0] v, input logic dec,
                                           input logic inc, input logic [9:0] lim);
    logic [9:0] r;
    case ({dec, inc})
      2'b10:   r = (v > CHANGES) ? (v - CHANGES) : 10'd0;
      2'b01:   r = (v < (lim - CHANGES)) ? (v + CHANGES) : lim;
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic pos_t init_pos(input int i);
    pos_t p;
    p.y = 10'(32'd20 + 32'd40 * (i / 32'd16));
    p.x = 10'(32'd20 + 32'd35 * (i % 32'd16));
    return p;
  endfunction

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic overlap(input pos_t a, input pos_t b);
    return (abs_diff(a.x, b.x) < SQUARE_SIZE) && (abs_diff(a.y, b.y) < SQUARE_SIZE);
  endfunction

endpackage

// File: rtl/square_step_clamp.sv
// Combinational one-frame step of a square position with clamping to the display area.
module square_step_clamp
  import square_pkg::*;
(
  input  pos_t cur,
  input  logic up,
  input  logic left,
  input  logic down,
  input  logic right,
  output pos_t nxt
);

  assign nxt.x = axis_step(cur.x, left, right, X_LIM);
  assign nxt.y = axis_step(cur.y, up, down, Y_LIM);

endmodule

// File: rtl/square_move_scheduler.sv
// Position table for NUM_SQUARES squares sharing one step/clamp datapath, one move per frame.
// Build option: SQUARE_COLLISION_EN inserts an overlap scan before the table write.
module square_move_scheduler
  import square_pkg::*;
#(
  parameter int NUM_SQUARES = 17,
  parameter int IDX_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refresh_tick,
  input  logic             btnU,
  input  logic             btnL,
  input  logic             btnD,
  input  logic             btnR,
  input  logic             btn_sel,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [19:0]      rd_pos,
  output logic [IDX_W-1:0] active_idx,
  output logic             busy,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_idx,
  output logic [19:0]      upd_pos
);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_SQUARES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE     = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0]   NUM_ENTRIES = (IDX_W+1)'(NUM_SQUARES);

  state_t           state_r;
  state_t           state_nxt_s;
  pos_t             table_r [NUM_SQUARES];
  logic [IDX_W-1:0] active_idx_r;
  logic             sel_prev_r;
  logic [3:0]       dir_r;
  pos_t             cur_r;
  pos_t             nxt_r;
  pos_t             step_s;
  logic             upd_valid_r;
  logic [IDX_W-1:0] upd_idx_r;
  pos_t             upd_pos_r;
  logic             sel_rise_s;
  logic             dir_any_s;
`ifdef SQUARE_COLLISION_EN
  logic [IDX_W-1:0] scan_j_r;
  logic             hit_r;
  logic             hit_now_s;
`endif

  assign sel_rise_s = btn_sel & ~sel_prev_r;
  assign dir_any_s  = btnU | btnL | btnD | btnR;

  square_step_clamp u_step (
    .cur   (cur_r),
    .up    (dir_r[3]),
    .left  (dir_r[2]),
    .down  (dir_r[1]),
    .right (dir_r[0]),
    .nxt   (step_s)
  );

`ifdef SQUARE_COLLISION_EN
  // Overlap test of the candidate position against the entry currently being scanned
  always_comb begin
    hit_now_s = 1'b0;
    if (scan_j_r != active_idx_r) begin
      hit_now_s = overlap(nxt_r, table_r[scan_j_r]);
    end else begin
      hit_now_s = 1'b0;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: a select rising edge consumes the frame, so no move starts with it
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (refresh_tick && !sel_rise_s && dir_any_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD:    state_nxt_s = ST_COMPUTE;
`ifdef SQUARE_COLLISION_EN
      ST_COMPUTE: state_nxt_s = ST_CHECK;
      ST_CHECK: begin
        if (scan_j_r == LAST_IDX) begin
          state_nxt_s = (hit_r || hit_now_s) ? ST_IDLE : ST_WRITE;
        end else begin
          state_nxt_s = ST_CHECK;
        end
      end
`else
      ST_COMPUTE: state_nxt_s = ST_WRITE;
`endif
      ST_WRITE:   state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Table, frame snapshot and load/compute/write datapath; reset abandons any in-flight move
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SQUARES; i++) begin
        table_r[i] <= init_pos(i);
      end
      active_idx_r <= {IDX_W{1'b0}};
      sel_prev_r   <= 1'b0;
      dir_r        <= 4'd0;
      cur_r        <= 20'd0;
      nxt_r        <= 20'd0;
      upd_valid_r  <= 1'b0;
      upd_idx_r    <= {IDX_W{1'b0}};
      upd_pos_r    <= 20'd0;
`ifdef SQUARE_COLLISION_EN
      scan_j_r     <= {IDX_W{1'b0}};
      hit_r        <= 1'b0;
`endif
    end else begin
      upd_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (refresh_tick) begin
            sel_prev_r <= btn_sel;
            dir_r      <= {btnU, btnL, btnD, btnR};
            if (sel_rise_s) begin
              active_idx_r <= (active_idx_r == LAST_IDX) ? {IDX_W{1'b0}} : (active_idx_r + IDX_ONE);
            end
          end
        end
        ST_LOAD: cur_r <= table_r[active_idx_r];
        ST_COMPUTE: begin
          nxt_r <= step_s;
`ifdef SQUARE_COLLISION_EN
          scan_j_r <= {IDX_W{1'b0}};
          hit_r    <= 1'b0;
`endif
        end
`ifdef SQUARE_COLLISION_EN
        ST_CHECK: begin
          scan_j_r <= scan_j_r + IDX_ONE;
          if (hit_now_s) begin
            hit_r <= 1'b1;
          end
        end
`endif
        ST_WRITE: begin
          table_r[active_idx_r] <= nxt_r;
          upd_valid_r           <= 1'b1;
          upd_idx_r             <= active_idx_r;
          upd_pos_r             <= nxt_r;
        end
        default: begin
          upd_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign rd_pos     = ({1'b0, rd_idx} < NUM_ENTRIES) ? table_r[rd_idx] : 20'd0;
  assign active_idx = active_idx_r;
  assign busy       = (state_r != ST_IDLE);
  assign upd_valid  = upd_valid_r;
  assign upd_idx    = upd_idx_r;
  assign upd_pos    = upd_pos_r;

endmodule
